aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Iterative AES-128 key-expansion engine that turns a 128-bit cipher key into the 11 round keys (round 0..10) and streams them, one per accepted transfer, to the round datapath. It drives the `rcon` module's `round` input and consumes its `rcon` word to build each new key. It uses four instances of the team S-box for SubWord.

## Interface
- `ROUNDS`, 10, number of expansion rounds; round keys produced = ROUNDS+1.
- `WORD_SIZE`, 32, key word width; passed to `rcon`.
- `KEY_SIZE`, 128, cipher/round key width (4 words).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request expansion of `key_in`; honoured only in IDLE.
- `key_in`  in  KEY_SIZE  cipher key, sampled on accepted `start`; word w0 = [127:96].
- `busy`  out  1  high from the cycle after accepted `start` through the final transfer cycle.
- `key_valid`  out  1  `round_key` holds a valid round key.
- `key_ready`  in  1  consumer accepts `round_key` when high with `key_valid`.
- `round_key`  out  KEY_SIZE  current round key.
- `key_round`  out  4  index (0..10) of `round_key`.
- `done`  out  1  one-cycle pulse after round-10 transfer.
- `rd_addr`  in  4  store read index (KEY_STORE_EN only).
- `rd_key`  out  KEY_SIZE  stored round key (KEY_STORE_EN only).
- `store_valid`  out  1  all 11 keys stored (KEY_STORE_EN only).

## Operation
- FSM states: IDLE, RUN, FIN.
- IDLE: `start`=1 latches `key_in` into `round_key`, sets `key_round`=0 and `key_valid`=1, and moves to RUN.
- RUN, transfer (`key_valid`&`key_ready`), `key_round`<10: load the next key and increment `key_round`.
  - Next-key equations: w0' = w0 ^ SubWord(RotWord(w3)) ^ rcon, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - RotWord(w) = {w[23:0], w[31:24]}.
  - SubWord applies the S-box bytewise.
- `rcon` round input = `key_round`+1, zero-extended to $clog2(ROUNDS)+1 bits.
- RUN, transfer with `key_round`=10: clear `key_valid`, go to FIN.
- RUN, no transfer: `round_key` and `key_round` hold stable (stall, any length).
- FIN: `done`=1 for one cycle, then IDLE.
- `start` in RUN or FIN is ignored. `key_in` changes after acceptance have no effect.
- All arithmetic is XOR. There are no carries and no widths beyond 32-bit words.

## Timing
- Reset values: `busy`=0, `key_valid`=0, `round_key`=0, `key_round`=0, `done`=0, FSM=IDLE.
  - With KEY_STORE_EN: `rd_key`=0, `store_valid`=0, store contents=0.
- `start` accepted at cycle T: round 0 valid at T+1.
- With `key_ready` held high, round r is valid at T+1+r, and the round-10 transfer happens at T+11.
- `done` is at T+12; `busy` falls at T+12. A new `start` is accepted at T+13 (IDLE).
- Each stall cycle delays all later events by one cycle.
- Next-key logic (S-box, rcon) is single-cycle combinational from registered `round_key`.
- `rst_n` low mid-expansion immediately returns all outputs to reset values and drops the partial key schedule.

## Configuration
- `AES_KEY_STORE_EN` defined: the block adds an 11×128 register store.
  - Each transfer writes `round_key` at index `key_round`.
  - `rd_key` is registered: 1-cycle latency from `rd_addr`; `rd_addr`>10 returns 0.
  - `store_valid` sets with `done` and clears on the next accepted `start`.
  - Supports decryption round-key replay in reverse order.
- Undefined: no store, and `rd_addr`, `rd_key` and `store_valid` ports are absent. The block is streaming only.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `key_ready`=1:
  - round 0 equals key_in; round 1 = a0fafe1788542cb123a339392a6c7605.
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 at T+11; `done` at T+12.
- Same key, `key_ready` low 3 cycles while round 4 is presented: round 4 value and `key_round`=4 stable, and all later events shift by 3 cycles.
- Pulse `start` with a different `key_in` during round 5: it is ignored, and the schedule matches the original key.
- `rst_n` low during round 7, release, start key 000102030405060708090a0b0c0d0e0f:
  - outputs are 0 during reset;
  - round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
- AES_KEY_STORE_EN, after FIPS-197 run:
  - `rd_addr`=1 gives a0fafe17…7605 one cycle later;
  - `rd_addr`=15 gives 0;
  - `store_valid`=1 until the next `start`.

Source files
------------

// File: rtl/aes_key_expand.sv
// aes_key_expand - iterative AES-128 key-expansion engine.
//
// Turns a 128-bit cipher key into the round keys 0..ROUNDS and presents
// them one at a time on a valid/ready handshake. The next key is computed
// combinationally from the registered round key, so a key is produced every
// cycle while the consumer keeps key_ready high.
//
// Optional feature: define AES_KEY_STORE_EN to add an (ROUNDS+1) x KEY_SIZE
// store of every transferred round key with a registered read port, which
// lets the decrypt path replay the schedule in reverse order.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        request expansion of key_in (honoured only in IDLE)
//   key_in       cipher key, word w0 = [127:96]
//   busy         high while round keys are being presented
//   key_valid    round_key holds a valid round key
//   key_ready    consumer accepts round_key when high with key_valid
//   round_key    current round key
//   key_round    index of round_key
//   done         one-cycle pulse after the final transfer
//   rd_addr      store read index           (AES_KEY_STORE_EN only)
//   rd_key       stored round key, 1-cycle  (AES_KEY_STORE_EN only)
//   store_valid  all round keys stored      (AES_KEY_STORE_EN only)

// aes_sbox - AES forward S-box computed as GF(2^8) inverse plus affine map.
//   din   input byte
//   dout  substituted byte
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] r;
    sq = a;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r;
  endfunction

  logic [7:0] inv;

  assign inv  = gf_inv(din);
  assign dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// rcon - round constant word for key-expansion round 1..ROUNDS.
//   round  expansion round index
//   rcon   round constant in the most significant byte, zeros below
module rcon #(
  parameter int WORD_SIZE = 32,
  parameter int ROUNDS    = 10
) (
  input  logic [$clog2(ROUNDS):0] round,
  output logic [WORD_SIZE-1:0]    rcon
);
  localparam int RW = $clog2(ROUNDS) + 1;

  logic [7:0] rc;

  always_comb begin
    rc = 8'h00;
    case (round)
      RW'(1):  rc = 8'h01;
      RW'(2):  rc = 8'h02;
      RW'(3):  rc = 8'h04;
      RW'(4):  rc = 8'h08;
      RW'(5):  rc = 8'h10;
      RW'(6):  rc = 8'h20;
      RW'(7):  rc = 8'h40;
      RW'(8):  rc = 8'h80;
      RW'(9):  rc = 8'h1b;
      RW'(10): rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

  assign rcon = {rc, {(WORD_SIZE-8){1'b0}}};
endmodule

module aes_key_expand #(
  parameter int ROUNDS    = 10,
  parameter int WORD_SIZE = 32,
  parameter int KEY_SIZE  = 128
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [KEY_SIZE-1:0] key_in,
  output logic                busy,
  output logic                key_valid,
  input  logic                key_ready,
  output logic [KEY_SIZE-1:0] round_key,
  output logic [3:0]          key_round,
  output logic                done
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]          rd_addr,
  output logic [KEY_SIZE-1:0] rd_key,
  output logic                store_valid
`endif
);
  localparam int RW = $clog2(ROUNDS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 xfer;
  logic                 last;
  logic [WORD_SIZE-1:0] w0, w1, w2, w3;
  logic [WORD_SIZE-1:0] rot, sub, rcon_word;
  logic [WORD_SIZE-1:0] n0, n1, n2, n3;
  logic [RW-1:0]        rcon_round;

  assign xfer = key_valid & key_ready;
  assign last = (key_round == 4'(ROUNDS));

  // Next-key datapath: one full expansion round from the registered key.
  assign {w0, w1, w2, w3} = round_key;
  assign rot        = {w3[23:0], w3[31:24]};
  assign rcon_round = RW'(key_round) + RW'(1);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot[8*b +: 8]),
      .dout (sub[8*b +: 8])
    );
  end

  rcon #(
    .WORD_SIZE (WORD_SIZE),
    .ROUNDS    (ROUNDS)
  ) u_rcon (
    .round (rcon_round),
    .rcon  (rcon_word)
  );

  assign n0 = w0 ^ sub ^ rcon_word;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (xfer && last) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; a key is presented for the whole of RUN.
  always_comb begin
    busy      = (state == RUN);
    key_valid = (state == RUN);
    done      = (state == FIN);
  end

  // Round key register: load on start, advance on each non-final transfer,
  // hold otherwise (covers consumer stalls of any length).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      round_key <= '0;
      key_round <= '0;
    end else if (state == IDLE && start) begin
      round_key <= key_in;
      key_round <= '0;
    end else if (state == RUN && xfer && !last) begin
      round_key <= {n0, n1, n2, n3};
      key_round <= key_round + 4'd1;
    end
  end

`ifdef AES_KEY_STORE_EN
  logic [KEY_SIZE-1:0] store [ROUNDS+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROUNDS + 1; i++) store[i] <= '0;
      rd_key      <= '0;
      store_valid <= 1'b0;
    end else begin
      if (state == RUN && xfer) store[key_round] <= round_key;
      rd_key <= (rd_addr <= 4'(ROUNDS)) ? store[rd_addr] : '0;
      // Rises together with done; a fresh start invalidates the old schedule.
      if (state == RUN && xfer && last)  store_valid <= 1'b1;
      else if (state == IDLE && start)   store_valid <= 1'b0;
    end
  end
`endif
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand - scoreboard bench for aes_key_expand.
// Expected round keys come from an independent key-schedule model (S-box by
// brute-force inverse search) and are queued when start is driven; each
// transfer pops and compares. Store checks are built with AES_KEY_STORE_EN.
module tb_aes_key_expand;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         key_ready = 1'b0;
  logic [127:0] key_in = '0;
  logic         busy, key_valid, done;
  logic [127:0] round_key;
  logic [3:0]   key_round;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_addr = '0;
  logic [127:0] rd_key;
  logic         store_valid;
`endif

  always #5 clk = ~clk;

  aes_key_expand dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_in      (key_in),
    .busy        (busy),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .round_key   (round_key),
    .key_round   (key_round),
    .done        (done)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_addr     (rd_addr),
    .rd_key      (rd_key),
    .store_valid (store_valid)
`endif
  );

  typedef struct {
    logic [127:0] key;
    logic [3:0]   rnd;
  } exp_t;

  exp_t         sb_q[$];
  int           n_chk = 0;
  int           n_fail = 0;
  logic [7:0]   sbox_t [256];
  logic [127:0] got_keys [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 1; i < r; i++) rc = xt(rc);
    {w0, w1, w2, w3} = k;
    t  = {w3[23:0], w3[31:24]};
    t  = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic check_reset_outputs(input string nm);
    check({nm, "_busy"},      128'(busy),      128'(0));
    check({nm, "_key_valid"}, 128'(key_valid), 128'(0));
    check({nm, "_round_key"}, round_key,       128'(0));
    check({nm, "_key_round"}, 128'(key_round), 128'(0));
    check({nm, "_done"},      128'(done),      128'(0));
`ifdef AES_KEY_STORE_EN
    check({nm, "_rd_key"},      rd_key,            128'(0));
    check({nm, "_store_valid"}, 128'(store_valid), 128'(0));
`endif
  endtask

  // Run one expansion. stall_at/poke_at/rst_at < 0 disable that event.
  // c counts cycles from the start-acceptance cycle (c = 0).
  task automatic expand(input logic [127:0] key, input int stall_at, input int stall_n,
                        input int poke_at, input int rst_at);
    logic [127:0] k;
    exp_t         e;
    int           c, stalled;
    bit           poked, fin, was_reset;
    k = key;
    for (int r = 0; r <= 10; r++) begin
      e.key = k;
      e.rnd = 4'(r);
      sb_q.push_back(e);
      if (r < 10) k = next_key(k, r + 1);
    end
    @(negedge clk);
    start = 1'b1;
    key_in = key;
    key_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key_in = ~key;
    c = 1; stalled = 0; poked = 0; fin = 0; was_reset = 0;
    while (!fin && c < 40) begin
      if (rst_at >= 0 && key_valid && int'(key_round) == rst_at) begin
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("in_reset");
        sb_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        fin = 1; was_reset = 1;
      end else if (done) begin
        check("done_time",      128'(c),         128'(12 + stall_n));
        check("busy_at_done",   128'(busy),      128'(0));
        check("valid_at_done",  128'(key_valid), 128'(0));
`ifdef AES_KEY_STORE_EN
        check("store_valid_at_done", 128'(store_valid), 128'(1));
`endif
        fin = 1;
      end else begin
        if (c == 1) begin
          check("busy_after_start", 128'(busy), 128'(1));
`ifdef AES_KEY_STORE_EN
          check("store_valid_cleared", 128'(store_valid), 128'(0));
`endif
        end
        key_ready = !(stall_at >= 0 && int'(key_round) == stall_at && stalled < stall_n);
        if (!key_ready && sb_q.size() > 0) begin
          check("stall_key",   round_key,       sb_q[0].key);
          check("stall_round", 128'(key_round), 128'(stall_at));
          stalled++;
        end
        if (poke_at >= 0 && !poked && int'(key_round) == poke_at) begin
          start = 1'b1;
          key_in = 128'h00112233445566778899aabbccddeeff;
          poked = 1;
        end else begin
          start = 1'b0;
        end
        if (!key_valid) begin
          check("valid_in_run", 128'(key_valid), 128'(1));
        end else if (key_ready) begin
          if (sb_q.size() == 0) begin
            check("scoreboard_empty", 128'(1), 128'(0));
          end else begin
            e = sb_q.pop_front();
            check("round_key",  round_key,       e.key);
            check("key_round",  128'(key_round), 128'(e.rnd));
            check("round_time", 128'(c),         128'(1 + int'(e.rnd) + stalled));
            got_keys[e.rnd] = round_key;
          end
        end
      end
      if (!fin) begin
        @(negedge clk);
        c++;
      end
    end
    if (!fin) check("timeout", 128'(c), 128'(0));
    start = 1'b0;
    key_ready = 1'b0;
    if (!was_reset) begin
      @(negedge clk);
      check("done_one_cycle", 128'(done), 128'(0));
      check("leftover_expected", 128'(sb_q.size()), 128'(0));
      sb_q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Plain FIPS-197 run with the consumer always ready.
    expand(FIPS_KEY, -1, 0, -1, -1);
    check("fips_round0",  got_keys[0],  FIPS_KEY);
    check("fips_round1",  got_keys[1],  FIPS_R1);
    check("fips_round10", got_keys[10], FIPS_R10);

`ifdef AES_KEY_STORE_EN
    rd_addr = 4'd1;
    @(negedge clk);
    check("store_rd1", rd_key, FIPS_R1);
    rd_addr = 4'd15;
    @(negedge clk);
    check("store_rd15", rd_key, 128'(0));
    rd_addr = 4'd10;
    @(negedge clk);
    check("store_rd10", rd_key, FIPS_R10);
    check("store_valid_idle", 128'(store_valid), 128'(1));
`endif

    // Consumer stall of 3 cycles on round 4.
    expand(FIPS_KEY, 4, 3, -1, -1);

    // start with another key during round 5 must be ignored.
    expand(FIPS_KEY, -1, 0, 5, -1);

    // Reset during round 7, then a fresh key.
    expand(FIPS_KEY, -1, 0, -1, 7);
    @(negedge clk);
    check_reset_outputs("after_reset");
    expand(SEQ_KEY, -1, 0, -1, -1);
    check("seq_round0",  got_keys[0],  SEQ_KEY);
    check("seq_round10", got_keys[10], SEQ_R10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
